// File: rtl/cpu7_exu_wbarb_pkg.sv
// Shared types and defaults for the integer register-file write-back arbiter.
package cpu7_exu_wbarb_pkg;

    localparam int GRLEN            = 32;
    localparam int WBARB_DEPTH      = 2;
    localparam int WBARB_STARVE_MAX = 4;

    // One late-write FIFO entry: live bit, destination register, write data.
    typedef struct packed {
        logic             live;
        logic [4:0]       rd;
        logic [GRLEN-1:0] data;
    } wb_entry_t;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_FIFO,
        GNT_BYPASS
    } wb_gnt_e;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        rd_onehot = 32'd1 << rd;
    endfunction

endpackage

// File: rtl/cpu7_exu_wbarb_fifo.sv
// Late-write FIFO: storage, wrapping pointers, occupancy, kill-by-rd and live mask.
module cpu7_exu_wbarb_fifo
    import cpu7_exu_wbarb_pkg::*;
#(
    parameter int DEPTH = WBARB_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  wb_entry_t   push_ent,
    input  logic        pop,
    input  logic        kill_en,
    input  logic [4:0]  kill_rd,
    output logic        full,
    output logic        empty,
    output wb_entry_t   head,
    output logic [31:0] live_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [GRLEN-1:0] data_q [DEPTH];
    logic [GRLEN-1:0] data_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state for storage and pointers; a younger pipeline write kills matching entries.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        live_d   = live_q;
        rd_d     = rd_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == kill_rd) live_d[i] = 1'b0;
            end
        end

        // Popped slots are cleared so live_q only ever marks occupied entries.
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end

        if (push) begin
            live_d[wr_ptr_q] = push_ent.live && !(kill_en && (push_ent.rd == kill_rd));
            rd_d[wr_ptr_q]   = push_ent.rd;
            data_d[wr_ptr_q] = push_ent.data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
    end

    // Control state: pointers, occupancy and live bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state is always written with non-blocking assignments.
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage.
    // NOTE: payload is not reset; it is only observed through a live bit, which is reset.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = '{live: live_q[rd_ptr_q], rd: rd_q[rd_ptr_q], data: data_q[rd_ptr_q]};

    // Destinations still owed a write by a live entry.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) live_mask = live_mask | rd_onehot(rd_q[i]);
        end
    end

endmodule

// File: rtl/cpu7_exu_wbarb.sv
// Write-back arbiter for the single integer register-file write port.
// The in-order W-stage write wins; late returns are bypassed when idle or queued.
module cpu7_exu_wbarb
    import cpu7_exu_wbarb_pkg::*;
#(
    parameter int DEPTH      = WBARB_DEPTH,
    parameter int STARVE_MAX = WBARB_STARVE_MAX
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ecl_wbarb_wen_w,
    input  logic [4:0]       ecl_wbarb_rd_w,
    input  logic [GRLEN-1:0] ecl_wbarb_data_w,
    input  logic             lsu_wbarb_valid,
    input  logic [4:0]       lsu_wbarb_rd,
    input  logic [GRLEN-1:0] lsu_wbarb_data,
    output logic             wbarb_lsu_ready,
    output logic             wbarb_ecl_stall,
    output logic             wbarb_irf_wen,
    output logic [4:0]       wbarb_irf_rd,
    output logic [GRLEN-1:0] wbarb_irf_wdata,
    output logic [31:0]      wbarb_pend_mask,
    output logic             wbarb_err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    wb_gnt_e          gnt;
    logic             pipe_req, lsu_fire;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t        fifo_head;
    logic             sel_wen;
    logic [4:0]       sel_rd;
    logic [GRLEN-1:0] sel_data;

    logic [4:0]       last_rd_q, last_rd_d;
    logic [GRLEN-1:0] last_wdata_q, last_wdata_d;
    logic [3:0]       starve_cnt_q, starve_cnt_d;
    logic             stall_q, stall_d;
    logic             err_q, err_d;

    // A write to r0 is no request; requests seen during reset are dropped.
    assign pipe_req        = resetn && ecl_wbarb_wen_w && (ecl_wbarb_rd_w != 5'd0);
    assign wbarb_lsu_ready = !fifo_full;
    assign lsu_fire        = resetn && lsu_wbarb_valid && wbarb_lsu_ready;

    // Fixed-priority grant of the write port.
    always_comb begin
        gnt = GNT_NONE;
        if (pipe_req)         gnt = GNT_PIPE;
        else if (!fifo_empty) gnt = GNT_FIFO;
        else if (lsu_fire)    gnt = GNT_BYPASS;
    end

    // Port mux, FIFO pop/push; an idle port repeats the last granted address and data.
    always_comb begin
        sel_wen  = 1'b0;
        sel_rd   = last_rd_q;
        sel_data = last_wdata_q;
        fifo_pop = 1'b0;
        unique case (gnt)
            GNT_PIPE: begin
                sel_wen  = 1'b1;
                sel_rd   = ecl_wbarb_rd_w;
                sel_data = ecl_wbarb_data_w;
            end
            GNT_FIFO: begin
                fifo_pop = 1'b1;
                if (fifo_head.live) begin
                    sel_wen  = 1'b1;
                    sel_rd   = fifo_head.rd;
                    sel_data = fifo_head.data;
                end
            end
            GNT_BYPASS: begin
                if (lsu_wbarb_rd != 5'd0) begin
                    sel_wen  = 1'b1;
                    sel_rd   = lsu_wbarb_rd;
                    sel_data = lsu_wbarb_data;
                end
            end
            default: ;
        endcase
        // Accepted late writes to r0 are swallowed; bypassed ones are already written.
        fifo_push = lsu_fire && (lsu_wbarb_rd != 5'd0) && (gnt != GNT_BYPASS);
    end

    assign wbarb_irf_wen   = sel_wen;
    assign wbarb_irf_rd    = sel_rd;
    assign wbarb_irf_wdata = sel_data;

    // Starvation counter, registered stall request and sticky protocol error.
    always_comb begin
        last_rd_d    = sel_wen ? sel_rd   : last_rd_q;
        last_wdata_d = sel_wen ? sel_data : last_wdata_q;

        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || fifo_pop) begin
            starve_cnt_d = 4'd0;
        end else if (fifo_head.live && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        stall_d = (starve_cnt_d == STARVE_LIM) ||
                  (fifo_full && lsu_wbarb_valid && !fifo_pop);
        err_d   = err_q || (pipe_req && stall_q);
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_rd_q    <= '0;
            last_wdata_q <= '0;
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            last_rd_q    <= last_rd_d;
            last_wdata_q <= last_wdata_d;
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= stall_d;
            err_q        <= err_d;
        end
    end

    assign wbarb_ecl_stall = stall_q;
    assign wbarb_err       = err_q;

    cpu7_exu_wbarb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_ent  ('{live: 1'b1, rd: lsu_wbarb_rd, data: lsu_wbarb_data}),
        .pop       (fifo_pop),
        .kill_en   (pipe_req),
        .kill_rd   (ecl_wbarb_rd_w),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .live_mask (wbarb_pend_mask)
    );

endmodule

// File: tb/tb_cpu7_exu_wbarb.sv
// Scoreboard bench for cpu7_exu_wbarb: a queue-based model predicts register-file
// writes and status; a negedge monitor compares every write the DUT presents.
module tb_cpu7_exu_wbarb;
    import cpu7_exu_wbarb_pkg::*;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             ecl_wbarb_wen_w = 1'b0;
    logic [4:0]       ecl_wbarb_rd_w = '0;
    logic [GRLEN-1:0] ecl_wbarb_data_w = '0;
    logic             lsu_wbarb_valid = 1'b0;
    logic [4:0]       lsu_wbarb_rd = '0;
    logic [GRLEN-1:0] lsu_wbarb_data = '0;
    logic             wbarb_lsu_ready, wbarb_ecl_stall, wbarb_irf_wen, wbarb_err;
    logic [4:0]       wbarb_irf_rd;
    logic [GRLEN-1:0] wbarb_irf_wdata;
    logic [31:0]      wbarb_pend_mask;

    always #5 clk = ~clk;

    cpu7_exu_wbarb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ecl_wbarb_wen_w  (ecl_wbarb_wen_w),
        .ecl_wbarb_rd_w   (ecl_wbarb_rd_w),
        .ecl_wbarb_data_w (ecl_wbarb_data_w),
        .lsu_wbarb_valid  (lsu_wbarb_valid),
        .lsu_wbarb_rd     (lsu_wbarb_rd),
        .lsu_wbarb_data   (lsu_wbarb_data),
        .wbarb_lsu_ready  (wbarb_lsu_ready),
        .wbarb_ecl_stall  (wbarb_ecl_stall),
        .wbarb_irf_wen    (wbarb_irf_wen),
        .wbarb_irf_rd     (wbarb_irf_rd),
        .wbarb_irf_wdata  (wbarb_irf_wdata),
        .wbarb_pend_mask  (wbarb_pend_mask),
        .wbarb_err        (wbarb_err)
    );

    // Reference model: queued late writes, starvation count, stall and error flags.
    typedef struct { logic [4:0] rd; logic [31:0] data; bit live; } ent_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
    ent_t mq[$];
    wr_t  exp_q[$];
    int   m_starve;
    bit   m_stall, m_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Status values sampled at the start of the most recent cycle().
    logic        seen_stall, seen_ready, seen_err;
    logic [31:0] seen_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock of stimulus; the pipeline obeys stall unless force_pw is set.
    task automatic cycle(input bit pw, input logic [4:0] prd, input logic [31:0] pdata,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ldata,
                         input bit force_pw, output bit acc);
        bit          pipe, was_empty, was_full, head_live, popped, bypass;
        logic [31:0] mask;
        ent_t        e;
        @(posedge clk); #1;
        if (m_stall && !force_pw) pw = 1'b0;
        ecl_wbarb_wen_w  = pw;
        ecl_wbarb_rd_w   = prd;
        ecl_wbarb_data_w = pdata;
        lsu_wbarb_valid  = lv;
        lsu_wbarb_rd     = lrd;
        lsu_wbarb_data   = ldata;

        mask = '0;
        foreach (mq[i]) if (mq[i].live) mask[mq[i].rd] = 1'b1;
        seen_stall = wbarb_ecl_stall;
        seen_ready = wbarb_lsu_ready;
        seen_err   = wbarb_err;
        seen_mask  = wbarb_pend_mask;
        check("ready", 64'(wbarb_lsu_ready), 64'(mq.size() < DEPTH));
        check("stall", 64'(wbarb_ecl_stall), 64'(m_stall));
        check("err", 64'(wbarb_err), 64'(m_err));
        check("pend_mask", 64'(wbarb_pend_mask), 64'(mask));

        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        head_live = !was_empty && mq[0].live;
        pipe      = pw && (prd != 5'd0);
        acc       = lv && !was_full;
        popped    = 1'b0;
        bypass    = 1'b0;
        if (pipe && m_stall) m_err = 1'b1;
        if (pipe) begin
            exp_q.push_back('{prd, pdata});
            foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
        end else if (!was_empty) begin
            e = mq.pop_front();
            popped = 1'b1;
            if (e.live) exp_q.push_back('{e.rd, e.data});
        end else if (acc) begin
            bypass = 1'b1;
            if (lrd != 5'd0) exp_q.push_back('{lrd, ldata});
        end
        if (acc && (lrd != 5'd0) && !bypass) mq.push_back('{lrd, ldata, !(pipe && (lrd == prd))});
        if (was_empty || popped) m_starve = 0;
        else if (head_live && m_starve < STARVE_MAX) m_starve++;
        m_stall = (m_starve == STARVE_MAX) || (was_full && lv && !popped);
    endtask

    task automatic step(input bit pw, input logic [4:0] prd, input logic [31:0] pdata,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
        bit a;
        cycle(pw, prd, pdata, lv, lrd, ldata, 1'b0, a);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        ecl_wbarb_wen_w = 1'b0;
        lsu_wbarb_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("rst_ready", 64'(wbarb_lsu_ready), 64'(1));
        check("rst_stall", 64'(wbarb_ecl_stall), 64'(0));
        check("rst_wen", 64'(wbarb_irf_wen), 64'(0));
        check("rst_rd", 64'(wbarb_irf_rd), 64'(0));
        check("rst_wdata", 64'(wbarb_irf_wdata), 64'(0));
        check("rst_mask", 64'(wbarb_pend_mask), 64'(0));
        check("rst_err", 64'(wbarb_err), 64'(0));
        mq.delete();
        exp_q.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_err    = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        if (resetn) begin
            if (wbarb_irf_wen) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got write r%0d=0x%0h expected no write",
                             wbarb_irf_rd, wbarb_irf_wdata);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_rd", 64'(wbarb_irf_rd), 64'(w.rd));
                    check("wr_data", 64'(wbarb_irf_wdata), 64'(w.data));
                end
            end else if (exp_q.size() != 0) begin
                n_checks++;
                $display("FAIL wr_missing: got no write expected r%0d=0x%0h",
                         exp_q[0].rd, exp_q[0].data);
                exp_q.delete();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a, lv_r;
        logic [4:0]  lrd_r;
        logic [31:0] ldata_r;
        int          first;

        do_reset();

        // Idle bypass: same-cycle write, nothing queued.
        step(0, 0, 0, 1, 5, 32'h1234);
        step(0, 0, 0, 0, 0, 0);
        check("bypass_mask", 64'(seen_mask), 64'(0));

        // Collision: pipeline r3 wins, r7 queued then written.
        step(1, 3, 32'hA, 1, 7, 32'hB);
        step(0, 0, 0, 0, 0, 0);
        check("collision_mask", 64'(seen_mask), 64'(32'h80));
        step(0, 0, 0, 0, 0, 0);
        check("collision_drain", 64'(seen_mask), 64'(0));

        // WAW kill: queued r9 is killed by a younger pipeline write to r9.
        step(1, 1, 32'h11, 1, 9, 32'h77);
        step(1, 9, 32'h55, 0, 0, 0);
        check("waw_mask_before", 64'(seen_mask), 64'(32'h200));
        step(0, 0, 0, 0, 0, 0);
        check("waw_mask_after", 64'(seen_mask), 64'(0));
        step(0, 0, 0, 0, 0, 0);

        // Starvation: stall seen on the 5th denied cycle.
        step(1, 1, 32'h1, 1, 4, 32'h44);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 32'(k), 0, 0, 0);
            if (seen_stall && first == 0) first = k;
        end
        check("starve_stall_cycle", 64'(first), 64'(5));

        // Back-pressure, forced protocol error, then in-order drain.
        step(1, 1, 32'h2, 1, 10, 32'hA0);
        step(1, 1, 32'h3, 1, 11, 32'hB0);
        step(1, 1, 32'h4, 1, 12, 32'hC0);
        check("bp_ready_low", 64'(seen_ready), 64'(0));
        cycle(1, 2, 32'h99, 1, 12, 32'hC0, 1'b1, a);
        check("bp_stall_high", 64'(seen_stall), 64'(1));
        a = 1'b0;
        for (int k = 0; k < 8 && !a; k++) begin
            cycle(0, 0, 0, 1, 12, 32'hC0, 1'b0, a);
            if (k == 0) check("err_sticky", 64'(seen_err), 64'(1));
        end
        check("bp_third_accepted", 64'(a), 64'(1));
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);

        // Reset with two entries queued.
        step(1, 1, 32'h5, 1, 20, 32'hD0);
        step(1, 1, 32'h6, 1, 21, 32'hD1);
        do_reset();

        // Late write to r0: accepted, never written.
        cycle(0, 0, 0, 1, 0, 32'hDEAD, 1'b0, a);
        check("rd0_accepted", 64'(a), 64'(1));
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic with a held late request, rising pipeline load.
        lv_r = 1'b0; lrd_r = '0; ldata_r = '0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 400; n++) begin
                if (!lv_r && $urandom_range(99) < 50) begin
                    lv_r    = 1'b1;
                    lrd_r   = 5'($urandom_range(7));
                    ldata_r = $urandom;
                end
                cycle($urandom_range(99) < 20 + 25 * ph, 5'($urandom_range(7)), $urandom,
                      lv_r, lrd_r, ldata_r, 1'b0, a);
                if (a) lv_r = 1'b0;
            end
        end
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu7_exu_wbarb.md
Name: cpu7_exu_wbarb

Overview:
- Write-back port arbiter for the integer register file's single write port (waddr1/wen1/wdata1).
- Two requesters share the port:
  - the in-order pipeline W-stage write from cpu7_exu_ecl, which has priority;
  - a late, long-latency returner (load/mul-div) that uses valid/ready and is buffered in a small FIFO.
- The block also issues the W-stage stall and publishes a pending-destination mask that decode uses for interlock.

Parameters:
- DEPTH, 2, late-write FIFO entries; power of 2, minimum 2.
- STARVE_MAX, 4, consecutive denied cycles of a live FIFO head before a forced stall; range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ecl_wbarb_wen_w  in  1  pipeline W-stage write request
- ecl_wbarb_rd_w  in  5  pipeline destination register
- ecl_wbarb_data_w  in  `GRLEN  pipeline write data
- lsu_wbarb_valid  in  1  late write valid
- lsu_wbarb_rd  in  5  late destination register
- lsu_wbarb_data  in  `GRLEN  late write data
- wbarb_lsu_ready  out  1  late write accepted when valid and ready are both 1
- wbarb_ecl_stall  out  1  registered; the W stage must carry a bubble (wen_w=0) while it is 1
- wbarb_irf_wen  out  1  register-file write enable
- wbarb_irf_rd  out  5  register-file write address
- wbarb_irf_wdata  out  `GRLEN  register-file write data
- wbarb_pend_mask  out  32  bit r = 1 while a live FIFO entry targets r
- wbarb_err  out  1  sticky protocol error

Behaviour:
- Reset (resetn=0, asynchronous):
  - FIFO emptied, starve counter cleared, stall cleared, err cleared.
  - Outputs: wbarb_lsu_ready=1, wbarb_ecl_stall=0, wbarb_irf_wen=0, wbarb_irf_rd=0, wbarb_irf_wdata=0, wbarb_pend_mask=0, wbarb_err=0.
  - A late request in flight during reset is lost. The requester must re-issue it.
- Effective requests:
  - A pipeline write to rd=0 is treated as no request and frees the port that cycle.
  - A late request to rd=0 is accepted (ready handshake completes) and discarded.
- Grant priority, evaluated each cycle combinationally; the irf outputs are combinational:
  1. Effective pipeline write: irf driven from the ecl_* inputs.
  2. Otherwise, FIFO non-empty: pop the head. wen=1 only if the head is live; a dead head pops with wen=0.
  3. Otherwise, FIFO empty and late valid & ready: bypass, i.e. write lsu_* directly in the same cycle with 0 latency, and nothing is enqueued.
  4. Otherwise wen=0. rd and wdata then hold their last granted values; reset value is 0.
- Enqueue:
  - Accepted late requests that were not bypassed go to the tail.
  - wbarb_lsu_ready = !full, taken from registered count.
  - Simultaneous pop and push when full: push is refused because ready was already 0.
  - Simultaneous pop and push when not full: both happen and count is unchanged.
  - Pointers wrap modulo DEPTH.
- WAW kill:
  - A granted pipeline write to rd X marks every live FIFO entry with rd==X dead (the pipeline instruction is younger).
  - An entry pushed in that same cycle with rd==X is also enqueued dead.
  - wbarb_pend_mask includes live entries only and is updated registered.
- Starvation:
  - starve_cnt increments each cycle the head is live and not granted.
  - It clears on any pop or when the FIFO is empty, and saturates at STARVE_MAX.
  - The cycle after starve_cnt==STARVE_MAX, or while full with lsu valid, wbarb_ecl_stall=1.
  - Stall drops the cycle after the head pops.
- Protocol:
  - ecl_wbarb_wen_w=1 with rd!=0 while wbarb_ecl_stall=1 sets wbarb_err (sticky until reset).
  - In that case the pipeline still wins.
- Invariants:
  - At most one rf write per cycle.
  - FIFO entries write in arrival order.

Decomposition:
- Add to common.vh:
  - `WBARB_DEPTH
  - `WBARB_STARVE_MAX
  - FIFO entry layout: live bit, rd[4:0], data[`GRLEN-1:0]
- One sub-module, cpu7_exu_wbarb_fifo: storage, pointers, count, per-entry kill-by-rd compare, live mask.
- Arbitration, bypass and starvation logic stay in cpu7_exu_wbarb.

Test Plan:
- Idle bypass: late valid, rd=5, data=0x1234, no pipeline write -> same cycle irf_wen=1, rd=5, wdata=0x1234; FIFO count stays 0.
- Collision:
  - Stimulus: pipeline rd=3 data=0xA and late rd=7 data=0xB in the same cycle.
  - Cycle 0: irf writes r3=0xA; pend_mask[7]=1 from the next edge.
  - Cycle 1, pipeline idle: irf writes r7=0xB and pend_mask becomes 0.
- WAW kill:
  - Stimulus: late rd=9 queued, then pipeline writes rd=9 data=0x55.
  - Response: r9=0x55, the FIFO entry pops with wen=0, and r9 is never overwritten by stale data.
- Full/back-pressure:
  - Stimulus: DEPTH=2, continuous pipeline writes to r1, late valid for 3 requests.
  - Response: 2 accepted, ready=0 on the third, stall=1.
  - After the pipeline bubbles: FIFO drains in order, then the third is accepted.
- Starvation: STARVE_MAX=4, head live, pipeline writing every cycle -> stall rises on the 5th denied cycle; head written in the first bubble cycle.
- Reset mid-operation and rd=0:
  - Reset asserted with 2 entries queued -> immediately mask=0, ready=1, irf_wen=0.
  - Late rd=0 -> accepted, no write.
  - Pipeline wen with stall=1 -> err=1.
